// File: rtl/img_mem_ctrl.sv
// img_mem_ctrl: frame-capture sequencer plus a two-client round-robin read arbiter for an image memory.
// Reads yield to the memory write path whenever mem_w_busy is high.
module img_mem_ctrl #(
    parameter int IMG_WIDTH = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIXELS = IMG_WIDTH * IMG_HEIGHT,
    parameter int DATA_WIDTH = 8,
    localparam int AW = $clog2(PIXELS)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  cap_start,
    output logic                  cap_busy,
    output logic                  cap_done,
    output logic [7:0]            frame_cnt,
    output logic                  mem_w_req,
    input  logic                  mem_w_busy,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [AW-1:0]         addr0,
    input  logic [AW-1:0]         addr1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [AW-1:0]         mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout
);
    typedef enum logic [1:0] {IDLE, ARMED, WRITING} state_t;
    state_t state, state_nx;
    logic finish;
    logic last;
    logic [AW-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (!n_rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        finish = state == WRITING && !mem_w_busy;
        if (state == IDLE && cap_start) state_nx = ARMED;
        else if (state == ARMED && mem_w_busy) state_nx = WRITING;
        else if (finish) state_nx = IDLE;
    end

    assign mem_w_req = state == ARMED;
    assign cap_busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cap_done <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            cap_done <= finish;
            if (finish) frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // last holds the most recently granted client; reset to 1 so client 0 wins the first tie
    assign gnt0 = !mem_w_busy && req0 && (!req1 || last);
    assign gnt1 = !mem_w_busy && req1 && (!req0 || !last);
    assign mem_r_addr = gnt0 ? addr0 : gnt1 ? addr1 : addr_q;
    assign rdata = mem_dout;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            last <= 1'b1;
            addr_q <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            last <= gnt1 ? 1'b1 : gnt0 ? 1'b0 : last;
            addr_q <= mem_r_addr;
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
        end
    end
endmodule

// File: tb/tb_img_mem_ctrl.sv
// tb_img_mem_ctrl: directed checks of capture sequencing, frame counting, reset and read arbitration.
module tb_img_mem_ctrl;
    localparam int AW = $clog2(640 * 480);
    logic clk = 1'b0;
    logic n_rst, cap_start, cap_busy, cap_done, mem_w_req, mem_w_busy;
    logic [7:0] frame_cnt, rdata, mem_dout;
    logic req0, req1, gnt0, gnt1, rvalid0, rvalid1;
    logic [AW-1:0] addr0, addr1, mem_r_addr;
    int errors = 0;
    int checks = 0;

    img_mem_ctrl dut (
        .clk(clk), .n_rst(n_rst), .cap_start(cap_start), .cap_busy(cap_busy),
        .cap_done(cap_done), .frame_cnt(frame_cnt), .mem_w_req(mem_w_req),
        .mem_w_busy(mem_w_busy), .req0(req0), .req1(req1), .addr0(addr0),
        .addr1(addr1), .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0),
        .rvalid1(rvalid1), .rdata(rdata), .mem_r_addr(mem_r_addr), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cap_busy"}, cap_busy, 0);
        check({tag, " cap_done"}, cap_done, 0);
        check({tag, " frame_cnt"}, frame_cnt, 0);
        check({tag, " mem_w_req"}, mem_w_req, 0);
        check({tag, " rvalid0"}, rvalid0, 0);
        check({tag, " rvalid1"}, rvalid1, 0);
        check({tag, " mem_r_addr"}, mem_r_addr, 0);
    endtask

    // one capture with cap_start held high for part of WRITING; the held request must be ignored
    task automatic capture(input logic [7:0] cnt_after);
        cap_start = 1'b1;
        step;
        cap_start = 1'b0;
        mem_w_busy = 1'b1;
        step;
        cap_start = 1'b1;
        step;
        step;
        cap_start = 1'b0;
        mem_w_busy = 1'b0;
        step;
        check("wrap cap_done", cap_done, 1);
        check("wrap cap_busy", cap_busy, 0);
        check("wrap frame_cnt", frame_cnt, cnt_after);
    endtask

    initial begin
        n_rst = 1'b0; cap_start = 1'b0; mem_w_busy = 1'b0; mem_dout = 8'h00;
        req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        step;
        step;
        check_reset_outputs("reset");
        n_rst = 1'b1;
        step;

        cap_start = 1'b1;
        step;
        cap_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("armed mem_w_req", mem_w_req, 1);
            check("armed cap_busy", cap_busy, 1);
            if (i == 4) mem_w_busy = 1'b1;
            step;
        end
        for (int j = 0; j < 99; j++) begin
            check("writing mem_w_req", mem_w_req, 0);
            check("writing cap_busy", cap_busy, 1);
            check("writing cap_done", cap_done, 0);
            step;
        end
        mem_w_busy = 1'b0;
        #1;
        check("last write cap_busy", cap_busy, 1);
        check("last write cap_done", cap_done, 0);
        step;
        check("done pulse", cap_done, 1);
        check("done frame_cnt", frame_cnt, 1);
        check("done cap_busy", cap_busy, 0);
        step;
        check("done one cycle", cap_done, 0);
        check("done frame_cnt hold", frame_cnt, 1);

        req0 = 1'b1; req1 = 1'b1; addr0 = 'h10; addr1 = 'h20;
        for (int i = 0; i < 6; i++) begin
            mem_dout = 8'hA0 + 8'(i);
            #1;
            check("rr gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
            check("rr gnt1", gnt1, (i % 2 == 1) ? 1 : 0);
            check("rr mem_r_addr", mem_r_addr, (i % 2 == 0) ? 'h10 : 'h20);
            check("rr rdata", rdata, 8'hA0 + 8'(i));
            if (i > 0) begin
                check("rr rvalid0", rvalid0, (i % 2 == 1) ? 1 : 0);
                check("rr rvalid1", rvalid1, (i % 2 == 0) ? 1 : 0);
            end
            step;
        end

        req1 = 1'b0; addr0 = 'h123; mem_w_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("blocked gnt0", gnt0, 0);
            check("blocked mem_r_addr", mem_r_addr, 'h20);
            check("ext write idle", cap_busy, 0);
            step;
        end
        mem_w_busy = 1'b0;
        #1;
        check("unblock gnt0", gnt0, 1);
        check("unblock mem_r_addr", mem_r_addr, 'h123);
        step;
        req0 = 1'b0;
        #1;
        check("unblock rvalid0", rvalid0, 1);
        check("unblock rvalid1", rvalid1, 0);
        check("addr hold", mem_r_addr, 'h123);
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check("rr after single gnt1", gnt1, 1);
        check("rr after single gnt0", gnt0, 0);
        step;
        req0 = 1'b0; req1 = 1'b0;

        for (int k = 2; k <= 256; k++) capture(8'(k));
        cap_start = 1'b1;
        step;
        cap_start = 1'b0;
        check("start on done cap_busy", cap_busy, 1);
        check("start on done mem_w_req", mem_w_req, 1);
        mem_w_busy = 1'b1;
        step;
        check("pre-reset writing", cap_busy, 1);
        n_rst = 1'b0;
        mem_w_busy = 1'b0;
        step;
        check_reset_outputs("mid reset");
        n_rst = 1'b1;
        step;
        check("post reset cap_done", cap_done, 0);
        check("post reset frame_cnt", frame_cnt, 0);
        check("post reset cap_busy", cap_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/img_mem_ctrl.md
IMG_MEM_CTRL -- requirements
Module: img_mem_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, image width in pixels.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, image height in lines.
REQ-003 SHALL have parameter PIXELS, default IMG_WIDTH*IMG_HEIGHT, frame size; address width AW = $clog2(PIXELS).
REQ-004 SHALL have parameter DATA_WIDTH, default 8, pixel width.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 n_rst  input  1  reset, synchronous, active-low.
REQ-007 cap_start  input  1  single-cycle request to capture the next full frame.
REQ-008 cap_busy  output  1  high while a capture is armed or being written.
REQ-009 cap_done  output  1  single-cycle pulse when a capture completes.
REQ-010 frame_cnt  output  8  number of completed captures, modulo 256.
REQ-011 mem_w_req  output  1  write request to image memory.
REQ-012 mem_w_busy  input  1  image memory write-in-progress flag.
REQ-013 req0, req1  input  1 each  read requests from client 0 (display) and client 1 (processing).
REQ-014 addr0, addr1  input  AW each  read addresses of clients 0 and 1.
REQ-015 gnt0, gnt1  output  1 each  combinational grant: request accepted this cycle.
REQ-016 rvalid0, rvalid1  output  1 each  read data valid for client 0 / 1.
REQ-017 rdata  output  DATA_WIDTH  read data; shared by both clients; qualified by rvalidN.
REQ-018 mem_r_addr  output  AW  read address to image memory.
REQ-019 mem_dout  input  DATA_WIDTH  image memory read data, one-cycle latency after address.

Function
REQ-020 Capture FSM SHALL have states IDLE, ARMED, WRITING.
REQ-021 IDLE -> ARMED when cap_start=1; cap_start SHALL be ignored in ARMED and WRITING.
REQ-022 mem_w_req SHALL be 1 exactly in ARMED.
REQ-023 ARMED -> WRITING on the first cycle mem_w_busy=1.
REQ-024 WRITING -> IDLE on the first cycle mem_w_busy=0; cap_done SHALL pulse 1 in the cycle after that transition decision (registered), and frame_cnt SHALL increment on the same edge, wrapping 255 -> 0.
REQ-025 cap_busy SHALL be 1 in ARMED and WRITING, 0 in IDLE.
REQ-026 cap_start asserted in the same cycle as cap_done SHALL be accepted (FSM is IDLE then).
REQ-027 mem_w_busy=1 while in IDLE (external write) SHALL NOT change FSM state but SHALL block reads.
REQ-028 Read arbiter SHALL grant at most one client per cycle, and only when mem_w_busy=0.
REQ-029 Single requester SHALL be granted immediately; with both requesting, round-robin: grant the client not granted most recently.
REQ-030 Round-robin pointer SHALL update only on a grant.
REQ-031 mem_r_addr SHALL equal addr of granted client; with no grant, it SHALL hold the last granted address.
REQ-032 rvalidN SHALL be registered: 1 in the cycle after gntN=1, else 0; rdata = mem_dout passthrough.
REQ-033 Ungranted requests SHALL remain pending (clients hold reqN/addrN until gntN); no internal request queueing.

Reset
REQ-034 On n_rst=0 at a clock edge: FSM=IDLE, cap_busy=0, cap_done=0, frame_cnt=0, mem_w_req=0, rvalid0=rvalid1=0, mem_r_addr=0, round-robin pointer favours client 0 next.
REQ-035 Reset mid-capture SHALL abandon the capture without a cap_done pulse or frame_cnt increment.

Verification
REQ-036 cap_start pulse, mem_w_busy rises 5 cycles later for 100 cycles -> mem_w_req 1 for those 5 cycles, cap_busy 1 throughout, one cap_done pulse after fall, frame_cnt=1.
REQ-037 req0=req1=1 continuously, mem_w_busy=0 -> grants alternate 0,1,0,1 starting with client 0; rvalid follows each grant by one cycle with rdata=mem_dout.
REQ-038 req0=1 addr0=0x123 with mem_w_busy=1 for 10 cycles -> gnt0=0 for 10 cycles, gnt0=1 the first cycle busy is 0, mem_r_addr=0x123, rvalid0 next cycle.
REQ-039 256 complete captures -> frame_cnt wraps to 0; cap_start held during WRITING -> no second capture.
REQ-040 n_rst=0 during WRITING -> all outputs at reset values next cycle, no cap_done, frame_cnt unchanged at 0 after reset.
